// File: rtl/pw_capture_sequencer_pkg.sv
// Shared FIFO command codes, field widths and state encoding for the
// front-end capture sequencer.
package pw_capture_sequencer_pkg;

   localparam int FE_FIFO_CMD_LEN  = 2;
   localparam int FE_FIFO_DATA_LEN = 8;
   localparam int FE_FIFO_STAT_LEN = 5;

   localparam logic [FE_FIFO_CMD_LEN-1:0] FE_FIFO_CMD_DATA = 2'd0;
   localparam logic [FE_FIFO_CMD_LEN-1:0] FE_FIFO_CMD_STAT = 2'd1;
   localparam logic [FE_FIFO_CMD_LEN-1:0] FE_FIFO_CMD_TIME = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_MATCH = 3'd1,
      S_CAPTURE    = 3'd2,
      S_PEND       = 3'd3,
      S_DONE       = 3'd4
   } cap_state_t;

   typedef struct packed {
      logic [FE_FIFO_CMD_LEN-1:0]  cmd;
      logic [FE_FIFO_DATA_LEN-1:0] data;
      logic [FE_FIFO_STAT_LEN-1:0] stat;
   } fe_entry_t;

endpackage

// File: rtl/pw_capture_sequencer_if.sv
// Control, PHY sniff and FIFO command signals of the capture sequencer.
interface pw_capture_sequencer_if
   import pw_capture_sequencer_pkg::*;
#(
   parameter int pTIMESTAMP_FULL_WIDTH = 16,
   parameter int pCAPTURE_LEN_WIDTH    = 16
);
   logic                             arm_i;
   logic                             timestamps_disable_i;
   logic [pCAPTURE_LEN_WIDTH-1:0]    capture_len_i;
   logic                             match_i;
   logic                             fifo_full_i;
   logic [FE_FIFO_DATA_LEN-1:0]      usb_data_i;
   logic                             usb_data_valid_i;
   logic [FE_FIFO_STAT_LEN-1:0]      usb_stat_i;
   logic                             usb_stat_valid_i;

   logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fe_capture_time;
   logic [FE_FIFO_DATA_LEN-1:0]      O_fe_capture_data;
   logic [FE_FIFO_STAT_LEN-1:0]      O_fe_capture_stat;
   logic [FE_FIFO_CMD_LEN-1:0]       O_fe_capture_cmd;
   logic                             O_fe_capture_data_wr;
   logic                             O_capturing;
   logic                             O_done;
   logic                             O_overflow;

   modport slave (
      input  arm_i, timestamps_disable_i, capture_len_i, match_i, fifo_full_i,
             usb_data_i, usb_data_valid_i, usb_stat_i, usb_stat_valid_i,
      output O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat,
             O_fe_capture_cmd, O_fe_capture_data_wr, O_capturing, O_done, O_overflow
   );

   modport master (
      output arm_i, timestamps_disable_i, capture_len_i, match_i, fifo_full_i,
             usb_data_i, usb_data_valid_i, usb_stat_i, usb_stat_valid_i,
      input  O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat,
             O_fe_capture_cmd, O_fe_capture_data_wr, O_capturing, O_done, O_overflow
   );

endinterface

// File: rtl/pw_capture_sequencer_delta_timer.sv
// Saturating delta timer: counts cycles since the last FIFO entry.
module pw_delta_timer #(
   parameter int pTIMESTAMP_FULL_WIDTH  = 16,
   parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
   input  logic                             fe_clk,
   input  logic                             reset_i,
   input  logic                             clear,
   output logic [pTIMESTAMP_FULL_WIDTH-1:0] delta,
   output logic                             saturated,
   output logic                             fits_short
);

   logic [pTIMESTAMP_FULL_WIDTH-1:0] count_q;

   // delta already includes the current cycle, so an event one cycle after
   // the last entry reports 1
   assign delta      = (count_q == '1) ? count_q : count_q + 1'b1;
   assign saturated  = (delta == '1);
   assign fits_short = ((delta >> pTIMESTAMP_SHORT_WIDTH) == '0);

   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= delta;
      end
   end

endmodule

// File: rtl/pw_capture_sequencer.sv
// Capture sequencer: waits for a pattern match, then formats sniffed bytes and
// status changes into timestamped DATA/STAT/TIME FIFO commands.
//
// state      | meaning
// S_IDLE     | disarmed, waiting for arm_i rising edge
// S_WAIT_MATCH | armed, waiting for match_i
// S_CAPTURE  | emitting entries, delta timer running
// S_PEND     | TIME entry written, held event goes out this cycle
// S_DONE     | capture length reached, waiting for arm_i low
module pw_capture_sequencer
   import pw_capture_sequencer_pkg::*;
#(
   parameter int pTIMESTAMP_FULL_WIDTH  = 16,
   parameter int pTIMESTAMP_SHORT_WIDTH = 3,
   parameter int pCAPTURE_LEN_WIDTH     = 16
) (
   input  logic                   fe_clk,
   input  logic                   reset_i,
   pw_capture_sequencer_if.slave  cap
);

   cap_state_t                       state_q, state_d;
   logic                             arm_q;
   logic [pCAPTURE_LEN_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
   fe_entry_t                        hold_q, hold_d;
   logic                             ovf_q, ovf_d;

   fe_entry_t                        ev_entry, emit_entry, out_q;
   logic                             ev_valid, emit, wr_q;
   logic [pTIMESTAMP_FULL_WIDTH-1:0] emit_time, time_q;

   logic                             delta_clr, delta_sat, delta_fits;
   logic [pTIMESTAMP_FULL_WIDTH-1:0] delta;

   pw_delta_timer #(
      .pTIMESTAMP_FULL_WIDTH  (pTIMESTAMP_FULL_WIDTH),
      .pTIMESTAMP_SHORT_WIDTH (pTIMESTAMP_SHORT_WIDTH)
   ) u_delta_timer (
      .fe_clk     (fe_clk),
      .reset_i    (reset_i),
      .clear      (delta_clr),
      .delta      (delta),
      .saturated  (delta_sat),
      .fits_short (delta_fits)
   );

   assign ev_valid = cap.usb_data_valid_i | cap.usb_stat_valid_i;

   always_comb begin
      ev_entry     = '0;
      ev_entry.cmd = cap.usb_data_valid_i ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
      if (cap.usb_data_valid_i) ev_entry.data = cap.usb_data_i;
      if (cap.usb_stat_valid_i) ev_entry.stat = cap.usb_stat_i;
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      hold_d     = hold_q;
      ovf_d      = ovf_q;
      emit       = 1'b0;
      emit_entry = '0;
      emit_time  = '0;
      delta_clr  = 1'b1;

      if (!cap.arm_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!arm_q) begin
                  state_d    = S_WAIT_MATCH;
                  ovf_d      = 1'b0;
                  byte_cnt_d = '0;
               end
            end
            S_WAIT_MATCH: begin
               if (cap.match_i) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               delta_clr = cap.timestamps_disable_i;
               if (cap.timestamps_disable_i) begin
                  if (ev_valid) begin
                     emit       = 1'b1;
                     emit_entry = ev_entry;
                  end
               end else if (ev_valid && delta_fits) begin
                  emit       = 1'b1;
                  emit_entry = ev_entry;
                  emit_time  = delta;
                  delta_clr  = 1'b1;
               end else if (ev_valid) begin
                  emit           = 1'b1;
                  emit_entry.cmd = FE_FIFO_CMD_TIME;
                  emit_time      = delta;
                  hold_d         = ev_entry;
                  state_d        = S_PEND;
                  delta_clr      = 1'b1;
               end else if (delta_sat) begin
                  emit           = 1'b1;
                  emit_entry.cmd = FE_FIFO_CMD_TIME;
                  emit_time      = delta;
                  delta_clr      = 1'b1;
               end
            end
            S_PEND: begin
               emit       = 1'b1;
               emit_entry = hold_q;
               state_d    = S_CAPTURE;
               if (ev_valid) ovf_d = 1'b1;
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
         endcase
      end

      // lost DATA entries still count so the length is in sniffed bytes
      if (emit && (emit_entry.cmd == FE_FIFO_CMD_DATA)) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
         if ((cap.capture_len_i != '0) && (byte_cnt_d == cap.capture_len_i)) state_d = S_DONE;
      end
      if (emit && cap.fifo_full_i) ovf_d = 1'b1;
   end

   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         arm_q      <= 1'b0;
         byte_cnt_q <= '0;
         hold_q     <= '0;
         ovf_q      <= 1'b0;
         wr_q       <= 1'b0;
         out_q      <= '0;
         time_q     <= '0;
      end else begin
         state_q    <= state_d;
         arm_q      <= cap.arm_i;
         byte_cnt_q <= byte_cnt_d;
         hold_q     <= hold_d;
         ovf_q      <= ovf_d;
         wr_q       <= emit & ~cap.fifo_full_i;
         if (emit && !cap.fifo_full_i) begin
            out_q  <= emit_entry;
            time_q <= emit_time;
         end else begin
            out_q  <= '0;
            time_q <= '0;
         end
      end
   end

   assign cap.O_fe_capture_data_wr = wr_q;
   assign cap.O_fe_capture_cmd     = out_q.cmd;
   assign cap.O_fe_capture_data    = out_q.data;
   assign cap.O_fe_capture_stat    = out_q.stat;
   assign cap.O_fe_capture_time    = time_q;
   assign cap.O_capturing          = (state_q == S_CAPTURE) || (state_q == S_PEND);
   assign cap.O_done               = (state_q == S_DONE);
   assign cap.O_overflow           = ovf_q;

endmodule

// File: tb/tb_pw_capture_sequencer.sv
// Bench for pw_capture_sequencer: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model.
module tb_pw_capture_sequencer;
   import pw_capture_sequencer_pkg::*;

   localparam int TW = 16;
   localparam int LW = 16;
   localparam int SAT = 65535;

   logic fe_clk  = 1'b0;
   logic reset_i = 1'b1;
   always #5 fe_clk = ~fe_clk;

   pw_capture_sequencer_if #(.pTIMESTAMP_FULL_WIDTH(TW), .pCAPTURE_LEN_WIDTH(LW)) bus ();

   pw_capture_sequencer #(
      .pTIMESTAMP_FULL_WIDTH  (TW),
      .pTIMESTAMP_SHORT_WIDTH (3),
      .pCAPTURE_LEN_WIDTH     (LW)
   ) dut (
      .fe_clk  (fe_clk),
      .reset_i (reset_i),
      .cap     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: phase flags, cycles since last entry, pending event
   bit         m_arm_prev, m_waiting, m_capturing, m_done, m_pend, m_ovf;
   int         m_since, m_bytes;
   logic [1:0] p_cmd;
   logic [7:0] p_data;
   logic [4:0] p_stat;
   bit         e_wr;
   logic [1:0] e_cmd;
   logic [15:0] e_time;
   logic [7:0] e_data;
   logic [4:0] e_stat;

   task automatic model_reset();
      m_arm_prev = 0; m_waiting = 0; m_capturing = 0; m_done = 0; m_pend = 0; m_ovf = 0;
      m_since = 0; m_bytes = 0;
      p_cmd = '0; p_data = '0; p_stat = '0;
      e_wr = 0; e_cmd = '0; e_time = '0; e_data = '0; e_stat = '0;
   endtask

   task automatic model_edge();
      bit ev, emit;
      logic [1:0] c, ec;
      logic [7:0] d, ed;
      logic [4:0] s, es;
      int t;
      ev = bus.usb_data_valid_i || bus.usb_stat_valid_i;
      ec = bus.usb_data_valid_i ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
      ed = bus.usb_data_valid_i ? bus.usb_data_i : 8'h00;
      es = bus.usb_stat_valid_i ? bus.usb_stat_i : 5'h00;
      emit = 0; c = '0; d = '0; s = '0; t = 0;
      if (!bus.arm_i) begin
         m_waiting = 0; m_capturing = 0; m_done = 0; m_pend = 0;
      end else if (!m_waiting && !m_capturing && !m_done) begin
         if (!m_arm_prev) begin m_waiting = 1; m_ovf = 0; m_bytes = 0; end
      end else if (m_waiting) begin
         if (bus.match_i) begin m_waiting = 0; m_capturing = 1; m_since = 0; end
      end else if (m_pend) begin
         emit = 1; c = p_cmd; d = p_data; s = p_stat; t = 0;
         m_pend = 0; m_since = 0;
         if (ev) m_ovf = 1;
      end else if (m_capturing) begin
         if (bus.timestamps_disable_i) begin
            m_since = 0;
            if (ev) begin emit = 1; c = ec; d = ed; s = es; end
         end else begin
            m_since = (m_since >= SAT) ? SAT : m_since + 1;
            if (ev && m_since < 8) begin
               emit = 1; c = ec; d = ed; s = es; t = m_since; m_since = 0;
            end else if (ev) begin
               emit = 1; c = FE_FIFO_CMD_TIME; t = m_since; m_since = 0;
               m_pend = 1; p_cmd = ec; p_data = ed; p_stat = es;
            end else if (m_since == SAT) begin
               emit = 1; c = FE_FIFO_CMD_TIME; t = SAT; m_since = 0;
            end
         end
      end
      if (emit && c == FE_FIFO_CMD_DATA) begin
         m_bytes = (m_bytes + 1) % 65536;
         if (bus.capture_len_i != 0 && m_bytes == int'(bus.capture_len_i)) begin
            m_capturing = 0; m_done = 1;
         end
      end
      if (emit && bus.fifo_full_i) m_ovf = 1;
      e_wr   = emit && !bus.fifo_full_i;
      e_cmd  = e_wr ? c : 2'd0;
      e_data = e_wr ? d : 8'd0;
      e_stat = e_wr ? s : 5'd0;
      e_time = e_wr ? 16'(t) : 16'd0;
      m_arm_prev = bus.arm_i;
   endtask

   function automatic logic [63:0] dut_vec();
      return {29'b0, bus.O_fe_capture_data_wr, bus.O_fe_capture_cmd, bus.O_fe_capture_time,
              bus.O_fe_capture_data, bus.O_fe_capture_stat, bus.O_capturing, bus.O_done,
              bus.O_overflow};
   endfunction

   function automatic logic [63:0] exp_vec();
      return {29'b0, e_wr, e_cmd, e_time, e_data, e_stat, m_capturing, m_done, m_ovf};
   endfunction

   task automatic step();
      @(posedge fe_clk);
      model_edge();
      #1;
      check("cycle", dut_vec(), exp_vec());
   endtask

   task automatic set_byte(input logic [7:0] d);
      bus.usb_data_i = d; bus.usb_data_valid_i = 1'b1;
   endtask

   task automatic no_ev();
      bus.usb_data_valid_i = 1'b0; bus.usb_stat_valid_i = 1'b0;
   endtask

   function automatic logic [63:0] wr_cmd_time();
      return {45'b0, bus.O_fe_capture_data_wr, bus.O_fe_capture_cmd, bus.O_fe_capture_time};
   endfunction

   initial begin
      int dens;
      bus.arm_i = 0; bus.timestamps_disable_i = 0; bus.capture_len_i = '0; bus.match_i = 0;
      bus.fifo_full_i = 0; bus.usb_data_i = '0; bus.usb_data_valid_i = 0;
      bus.usb_stat_i = '0; bus.usb_stat_valid_i = 0;
      model_reset();
      #12;
      check("reset", dut_vec(), 64'h0);
      reset_i = 1'b0;

      // two bytes, length 2
      bus.capture_len_i = 16'd2; bus.arm_i = 1; step();
      bus.match_i = 1; step(); bus.match_i = 0;
      step();
      set_byte(8'hA5); step(); no_ev();
      check("len2_first", {wr_cmd_time(), bus.O_fe_capture_data},
            {45'b0, 1'b1, FE_FIFO_CMD_DATA, 16'd2, 8'hA5});
      step();
      set_byte(8'h3C); step(); no_ev();
      check("len2_second", {wr_cmd_time(), bus.O_fe_capture_data},
            {45'b0, 1'b1, FE_FIFO_CMD_DATA, 16'd2, 8'h3C});
      check("len2_done", 64'(bus.O_done), 64'd1);
      set_byte(8'h77); repeat (3) step(); no_ev();
      check("done_no_wr", 64'(bus.O_fe_capture_data_wr), 64'd0);

      // long delta through PEND, byte during PEND dropped
      bus.arm_i = 0; step();
      bus.capture_len_i = '0; bus.arm_i = 1; step();
      bus.match_i = 1; step(); bus.match_i = 0;
      repeat (19) step();
      set_byte(8'h5A); step();
      check("long_time", wr_cmd_time(), {45'b0, 1'b1, FE_FIFO_CMD_TIME, 16'd20});
      set_byte(8'hC3); step(); no_ev();
      check("pend_held", {wr_cmd_time(), bus.O_fe_capture_data},
            {45'b0, 1'b1, FE_FIFO_CMD_DATA, 16'd0, 8'h5A});
      check("pend_ovf", {62'b0, bus.O_overflow, bus.O_capturing}, 64'd3);
      step();
      check("pend_drop", 64'(bus.O_fe_capture_data_wr), 64'd0);

      // idle saturation
      bus.arm_i = 0; step();
      bus.arm_i = 1; step();
      check("rearm_ovf_clr", 64'(bus.O_overflow), 64'd0);
      bus.match_i = 1; step(); bus.match_i = 0;
      repeat (SAT - 1) step();
      step();
      check("sat_time", wr_cmd_time(), {45'b0, 1'b1, FE_FIFO_CMD_TIME, 16'hFFFF});
      repeat (2) step();
      set_byte(8'h11); step(); no_ev();
      check("after_sat", wr_cmd_time(), {45'b0, 1'b1, FE_FIFO_CMD_DATA, 16'd3});

      // FIFO full loses the byte but it still counts toward length
      bus.arm_i = 0; step();
      bus.capture_len_i = 16'd1; bus.arm_i = 1; step();
      bus.match_i = 1; step(); bus.match_i = 0;
      step();
      set_byte(8'h99); bus.fifo_full_i = 1; step(); no_ev(); bus.fifo_full_i = 0;
      check("full_no_wr", 64'(bus.O_fe_capture_data_wr), 64'd0);
      check("full_ovf_done", {62'b0, bus.O_overflow, bus.O_done}, 64'd3);
      bus.arm_i = 0; step();
      bus.arm_i = 1; step();
      check("full_rearm", 64'(bus.O_overflow), 64'd0);

      // async reset mid-capture
      bus.capture_len_i = '0;
      bus.match_i = 1; step(); bus.match_i = 0;
      set_byte(8'h42); step(); no_ev(); step();
      reset_i = 1'b1;
      #2;
      check("async_rst", dut_vec(), 64'h0);
      model_reset();
      bus.arm_i = 0;
      #2 reset_i = 1'b0;
      set_byte(8'h24); repeat (3) step(); no_ev();
      check("rst_idle_wr", 64'(bus.O_fe_capture_data_wr), 64'd0);

      // arm low mid-capture
      bus.arm_i = 1; step();
      bus.match_i = 1; step(); bus.match_i = 0;
      set_byte(8'h81); step();
      bus.arm_i = 0; set_byte(8'h82); step(); no_ev();
      check("arm_low", {61'b0, bus.O_fe_capture_data_wr, bus.O_capturing, bus.O_done}, 64'd0);

      // random traffic
      for (int seg = 0; seg < 8; seg++) begin
         bus.capture_len_i = 16'($urandom_range(0, 6));
         bus.timestamps_disable_i = ($urandom_range(0, 3) == 0);
         dens = (seg % 3 == 0) ? 2 : (seg % 3 == 1) ? 6 : 25;
         bus.arm_i = 1;
         for (int i = 0; i < 400; i++) begin
            if (bus.arm_i && $urandom_range(0, 199) == 0) bus.arm_i = 0;
            else if (!bus.arm_i && $urandom_range(0, 2) == 0) bus.arm_i = 1;
            bus.match_i          = ($urandom_range(0, 14) == 0);
            bus.usb_data_valid_i = ($urandom % dens == 0);
            bus.usb_stat_valid_i = ($urandom % (dens * 2) == 0);
            bus.usb_data_i       = 8'($urandom);
            bus.usb_stat_i       = 5'($urandom);
            bus.fifo_full_i      = ($urandom_range(0, 11) == 0);
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pw_capture_sequencer.md
Name: pw_capture_sequencer

Overview:
Front-end capture sequencer in the fe_clk domain, sitting between the USB PHY sniff interface and the sniff FIFO write logic. Once armed, it waits for a pattern match, then timestamps and formats each byte and status event into FIFO commands (DATA, STAT, TIME). It stops after the programmed capture length. It drives the fe_capture_* inputs of the register/FIFO block and reports capture state back.

Parameters:
pTIMESTAMP_FULL_WIDTH, 16, width of the full delta timestamp carried by TIME entries
pTIMESTAMP_SHORT_WIDTH, 3, width of the short delta carried by DATA/STAT entries
pCAPTURE_LEN_WIDTH, 16, width of the capture length (byte) counter

Ports:
fe_clk  in  1  front-end clock (single clock domain)
reset_i  in  1  asynchronous, active-high reset
arm_i  in  1  level arm, already synchronised to fe_clk
timestamps_disable_i  in  1  1 = all deltas reported as 0, no TIME entries
capture_len_i  in  pCAPTURE_LEN_WIDTH  DATA entries to capture; 0 = unlimited
match_i  in  1  one-cycle pattern-match pulse
fifo_full_i  in  1  sniff FIFO full (write side)
usb_data_i  in  8  sniffed byte
usb_data_valid_i  in  1  byte strobe
usb_stat_i  in  5  PHY status bits
usb_stat_valid_i  in  1  status-change strobe
O_fe_capture_time  out  pTIMESTAMP_FULL_WIDTH  delta timestamp
O_fe_capture_data  out  8  byte
O_fe_capture_stat  out  5  status
O_fe_capture_cmd  out  2  FE_FIFO_CMD_DATA/STAT/TIME
O_fe_capture_data_wr  out  1  write strobe, one cycle per entry
O_capturing  out  1  high in CAPTURE/PEND
O_done  out  1  high in DONE
O_overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (async): state IDLE. All outputs 0. Delta counter 0. Byte counter 0.
- States and transitions:
  - IDLE -> WAIT_MATCH on arm_i rising edge. This edge also clears O_overflow.
  - WAIT_MATCH -> CAPTURE on match_i. The delta counter is cleared in the match cycle.
  - CAPTURE -> PEND when a TIME entry must precede the event.
  - PEND -> CAPTURE after one cycle.
  - CAPTURE -> DONE when the byte count equals capture_len_i (nonzero), evaluated after the write of the last DATA entry.
  - DONE holds until arm_i is low.
  - arm_i low in any state -> IDLE next cycle. An event in the same cycle is discarded.
- Event selection: if usb_data_valid_i and usb_stat_valid_i are high in the same cycle, emit one DATA entry carrying both data and stat. A STAT-only event emits STAT with data 0.
- Delta counter:
  - Increments every cycle in CAPTURE/PEND and saturates at all-ones.
  - Resets to 0 in the cycle any entry is written. After a TIME entry it resets to 0, so the following event carries delta 0.
- Short-delta path: if delta < 2^pTIMESTAMP_SHORT_WIDTH, the event is written the same cycle after registering, i.e. 1-cycle latency. O_fe_capture_time[SHORT-1:0] = delta; upper bits 0.
- Long-delta path: otherwise, write TIME with the full delta. Latch the event in a one-entry holding register and enter PEND. In PEND, write the held event with delta 0.
- Event arriving in PEND: dropped, O_overflow set.
- Idle saturation: delta reaching all-ones with no event writes a TIME entry with all-ones and restarts from 0. An event in that same cycle takes the long-delta path instead.
- timestamps_disable_i=1: delta forced to 0. No TIME entries and never PEND.
- fifo_full_i high in a write cycle:
  - Suppress O_fe_capture_data_wr and set O_overflow.
  - The entry is lost. The byte counter still increments for a lost DATA entry, so capture length is in sniffed bytes.
  - A held PEND event is also lost and the FSM returns to CAPTURE.
- Byte counter: counts DATA entries, pCAPTURE_LEN_WIDTH wide. With capture_len_i=0 it wraps silently and capture never ends.
- Events in IDLE, WAIT_MATCH and DONE are ignored. Entries are never written outside CAPTURE/PEND.

Decomposition:
- Shared defines: FE_FIFO_CMD_DATA/STAT/TIME codes, FE_FIFO_*_LEN field widths, state encoding localparams.
- Natural sub-module: pw_delta_timer, the saturating delta counter with clear, saturate and short-fits flags.

Test Plan:
- Arm, match, bytes 0xA5 and 0x3C 2 cycles apart, len=2 -> DATA(0xA5), DATA(0x3C, delta 2), then O_done=1, no further writes.
- Byte 20 cycles after match, SHORT=3 -> TIME(delta 20), next cycle DATA(byte, delta 0), O_capturing held through PEND.
- No events for 65535 cycles after match -> one TIME(0xFFFF), counter restarts; event 3 cycles later -> DATA delta 3.
- fifo_full_i=1 during a byte -> no wr strobe, O_overflow=1, byte counter +1; re-arm -> O_overflow=0.
- Byte during PEND -> dropped, O_overflow=1; held event still written.
- Async reset mid-CAPTURE, and arm_i low mid-CAPTURE -> IDLE, all outputs 0, later events produce no writes.
